// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add/subtract controller.
// State encoding is fixed so that downstream debug taps can decode it.
package serial_add_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// Combinational full adder assembled from two half-adder stages and a carry OR.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);

    logic hs1_s;
    logic hs1_c;
    logic hs2_c;

    assign hs1_s = x ^ y;
    assign hs1_c = x & y;

    assign s     = hs1_s ^ cin;
    assign hs2_c = hs1_s & cin;

    assign co    = hs1_c | hs2_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one shared full-adder cell, one operand bit
// per clock, LSB first, with a one-cycle done pulse when the result is complete.
//
//   state | meaning
//   IDLE  | waiting for start; ready high
//   RUN   | one bit-step per clock, counter 0..WIDTH-1; busy high
//   DONE  | result valid, done pulse; a new start is accepted here too
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t state_q;
    state_t state_nxt;

    logic             load;
    logic             step;
    logic             last_step;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sub_q;
    logic             carry_q;
    logic             cout_q;

    logic             bit_b;
    logic             fa_s;
    logic             fa_co;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        step      = 1'b0;
        last_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    last_step = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Back-to-back request: skip IDLE entirely.
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Subtraction is A + ~B + 1: invert B per bit and seed the carry with sub.
    assign bit_b = b_sh[0] ^ sub_q;

    fa_cell u_fa (
        .x   (a_sh[0]),
        .y   (bit_b),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (load) begin
            a_sh    <= a;
            b_sh    <= b;
            sub_q   <= sub;
            carry_q <= sub;
            cnt_q   <= '0;
        end else if (step) begin
            sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            carry_q <= fa_co;
            if (last_step) begin
                cout_q <= fa_co;
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign ready = (state_q == IDLE) || (state_q == DONE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule
